// File: rtl/tagged_flux_fifo.sv
// Multi-queue FIFO: tagged words from one write stream are sorted into FLUX circular queues
// and presented highest-numbered-non-empty-queue first on a per-flux read interface.
module tagged_flux_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
    localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic [FLUX-1:0]  read,
    output logic [FLUX-1:0]  empty,
    output logic [WIDTH-1:0] dout,
    output logic             overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [WIDTH-1:0] mem_q [FLUX][DEPTH];
    ptr_t             wptr_q [FLUX];
    ptr_t             wptr_d [FLUX];
    ptr_t             rptr_q [FLUX];
    ptr_t             rptr_d [FLUX];
    cnt_t             cnt_q  [FLUX];
    cnt_t             cnt_d  [FLUX];
    logic             err_q;
    logic             err_d;

    logic [FLUX-1:0]      q_empty;
    logic [FLUX-1:0]      q_full;
    logic [FLUX-1:0]      sel_oh;
    logic [TAG_WIDTH-1:0] sel;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          tag_ext;
    logic                 any_valid;
    logic                 tag_ok;
    logic                 rd_ok;
    logic                 rd_err;
    logic                 wr_ok;
    logic                 wr_err;

    assign tag     = din[WIDTH-1:DATA_WIDTH];
    assign tag_ext = 32'(tag);
    assign tag_ok  = tag_ext < FLUX;

    always_comb begin
        for (int q = 0; q < FLUX; q++) begin
            q_empty[q] = (cnt_q[q] == '0);
            q_full[q]  = (cnt_q[q] == CNT_W'(DEPTH));
        end
    end

    // Highest-numbered non-empty queue owns the output.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        for (int q = 0; q < FLUX; q++) begin
            if (!q_empty[q]) begin
                sel       = TAG_WIDTH'(q);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        if (any_valid) begin
            sel_oh[sel] = 1'b1;
        end
    end

    // Exactly one read bit, matching the selected non-empty queue.
    assign rd_ok  = any_valid && (read == sel_oh);
    assign rd_err = (|read) && !rd_ok;

    // Full blocks writes, except into the full queue whose head leaves in the same cycle.
    assign wr_ok  = write && tag_ok && (!full || (rd_ok && (sel == tag) && q_full[sel]));
    assign wr_err = write && !wr_ok;

    always_comb begin
        for (int q = 0; q < FLUX; q++) begin
            wptr_d[q] = wptr_q[q];
            rptr_d[q] = rptr_q[q];
            cnt_d[q]  = cnt_q[q];
            if (wr_ok && (tag == TAG_WIDTH'(q))) begin
                wptr_d[q] = wptr_q[q] + PTR_W'(1);
                cnt_d[q]  = cnt_d[q] + CNT_W'(1);
            end
            if (rd_ok && (sel == TAG_WIDTH'(q))) begin
                rptr_d[q] = rptr_q[q] + PTR_W'(1);
                cnt_d[q]  = cnt_d[q] - CNT_W'(1);
            end
        end
        err_d = err_q | wr_err | rd_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < FLUX; q++) begin
                wptr_q[q] <= '0;
                rptr_q[q] <= '0;
                cnt_q[q]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int q = 0; q < FLUX; q++) begin
                wptr_q[q] <= wptr_d[q];
                rptr_q[q] <= rptr_d[q];
                cnt_q[q]  <= cnt_d[q];
            end
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[tag][wptr_q[tag]] <= din;
        end
    end

    assign empty        = q_empty;
    assign full         = |q_full;
    assign dout         = any_valid ? mem_q[sel][rptr_q[sel]] : '0;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Scoreboard bench for tagged_flux_fifo (FLUX=2, DEPTH=4): per-queue expected-word queues are
// pushed on accepted writes and popped on accepted reads; outputs are sampled 1 time unit after posedge.
module tb_tagged_flux_fifo;

    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic [8:0] din;
    logic       full;
    logic [1:0] read;
    logic [1:0] empty;
    logic [8:0] dout;
    logic       overflow_err;

    int tests = 0;
    int fails = 0;

    logic [8:0] sb0[$];
    logic [8:0] sb1[$];
    logic       exp_err;

    always #5 clk = ~clk;

    tagged_flux_fifo #(
        .DATA_WIDTH(8),
        .FLUX      (2),
        .DEPTH     (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .din         (din),
        .full        (full),
        .read        (read),
        .empty       (empty),
        .dout        (dout),
        .overflow_err(overflow_err)
    );

    function automatic logic [1:0] exp_empty();
        return {sb1.size() == 0, sb0.size() == 0};
    endfunction

    function automatic logic exp_full();
        return (sb0.size() == DP) || (sb1.size() == DP);
    endfunction

    function automatic logic [8:0] exp_dout();
        if (sb1.size() != 0) return sb1[0];
        if (sb0.size() != 0) return sb0[0];
        return 9'h000;
    endfunction

    function automatic logic [1:0] exp_sel_oh();
        if (sb1.size() != 0) return 2'b10;
        if (sb0.size() != 0) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one cycle of stimulus and update the scoreboard with what should be accepted.
    task automatic apply(input logic w, input logic [8:0] d, input logic [1:0] r);
        logic rd_ok;
        logic wr_ok;
        write = w;
        din   = d;
        read  = r;
        rd_ok = (r != 2'b00) && (r == exp_sel_oh());
        wr_ok = w && (!exp_full() ||
                (rd_ok && ((d[8] && r[1] && sb1.size() == DP) ||
                           (!d[8] && r[0] && sb0.size() == DP))));
        if ((w && !wr_ok) || (r != 2'b00 && !rd_ok)) exp_err = 1'b1;
        if (rd_ok) begin
            if (r[1]) void'(sb1.pop_front());
            else      void'(sb0.pop_front());
        end
        if (wr_ok) begin
            if (d[8]) sb1.push_back(d);
            else      sb0.push_back(d);
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 2'b00;
        din   = 9'h000;
    endtask

    task automatic do_reset(input logic w, input logic [8:0] d);
        rst   = 1'b1;
        write = w;
        din   = d;
        read  = 2'b00;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        din   = 9'h000;
        sb0.delete();
        sb1.delete();
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 9'h000);
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL reset_empty: got %b want 11", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (dout !== 9'h000) begin fails++; $display("FAIL reset_dout: got %h want 000", dout); end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", overflow_err); end
    endtask

    task automatic test_basic();
        apply(1'b1, {1'b0, 8'hA5}, 2'b00);
        tests++; if (empty !== 2'b10) begin fails++; $display("FAIL basic_empty: got %b want 10", empty); end
        tests++; if (dout !== 9'h0A5) begin fails++; $display("FAIL basic_dout: got %h want 0a5", dout); end
        apply(1'b0, 9'h000, 2'b01);
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL basic_drain: got %b want 11", empty); end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", overflow_err); end
    endtask

    task automatic test_priority();
        apply(1'b1, {1'b0, 8'h11}, 2'b00);
        apply(1'b1, {1'b1, 8'h22}, 2'b00);
        apply(1'b1, {1'b0, 8'h33}, 2'b00);
        tests++; if (dout !== 9'h122) begin fails++; $display("FAIL prio_head1: got %h want 122", dout); end
        apply(1'b0, 9'h000, 2'b10);
        tests++; if (dout !== 9'h011) begin fails++; $display("FAIL prio_head0a: got %h want 011", dout); end
        apply(1'b0, 9'h000, 2'b01);
        tests++; if (dout !== 9'h033) begin fails++; $display("FAIL prio_head0b: got %h want 033", dout); end
        apply(1'b0, 9'h000, 2'b01);
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL prio_empty: got %b want 11", empty); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DP; i++) begin
            tests++; if (full !== 1'b0) begin fails++; $display("FAIL fill_notfull: got %b want 0", full); end
            apply(1'b1, {1'b1, 8'(8'h40 + i)}, 2'b00);
        end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (dout !== exp_dout()) begin fails++; $display("FAIL wrap_dout: got %h want %h", dout, exp_dout()); end
            apply(1'b1, {1'b1, 8'(8'h50 + i)}, 2'b10);
            tests++; if (full !== 1'b1) begin fails++; $display("FAIL wrap_full: got %b want 1", full); end
        end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL wrap_err: got %b want 0", overflow_err); end
        for (int i = 0; i < DP; i++) begin
            tests++; if (dout !== {1'b1, 8'(8'h54 + i)}) begin fails++; $display("FAIL wrap_drain: got %h want %h", dout, {1'b1, 8'(8'h54 + i)}); end
            apply(1'b0, 9'h000, 2'b10);
        end
        tests++; if (full !== 1'b0 || empty !== 2'b11) begin fails++; $display("FAIL wrap_end: got full=%b empty=%b want 0/11", full, empty); end
    endtask

    task automatic test_same_queue();
        apply(1'b1, {1'b0, 8'h44}, 2'b00);
        tests++; if (dout !== 9'h044) begin fails++; $display("FAIL same_old: got %h want 044", dout); end
        apply(1'b1, {1'b0, 8'h55}, 2'b01);
        tests++; if (empty !== 2'b10) begin fails++; $display("FAIL same_empty: got %b want 10", empty); end
        tests++; if (dout !== 9'h055) begin fails++; $display("FAIL same_new: got %h want 055", dout); end
        apply(1'b0, 9'h000, 2'b01);
        tests++; if (empty !== 2'b11 || overflow_err !== 1'b0) begin fails++; $display("FAIL same_end: got empty=%b err=%b want 11/0", empty, overflow_err); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DP; i++) apply(1'b1, {1'b1, 8'(8'h60 + i)}, 2'b00);
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b want 1", full); end
        apply(1'b1, {1'b0, 8'h77}, 2'b00);
        tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", overflow_err); end
        tests++; if (empty !== 2'b01) begin fails++; $display("FAIL ovf_dropped: got %b want 01", empty); end
        apply(1'b0, 9'h000, 2'b01);
        tests++; if (empty !== 2'b01 || dout !== 9'h160) begin fails++; $display("FAIL ovf_badread: got empty=%b dout=%h want 01/160", empty, dout); end
        apply(1'b0, 9'h000, 2'b11);
        tests++; if (dout !== 9'h160 || full !== 1'b1) begin fails++; $display("FAIL ovf_multiread: got dout=%h full=%b want 160/1", dout, full); end
        apply(1'b0, 9'h000, 2'b10);
        tests++; if (full !== 1'b0 || dout !== 9'h161) begin fails++; $display("FAIL ovf_fullfall: got full=%b dout=%h want 0/161", full, dout); end
        tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
        while (sb1.size() != 0) apply(1'b0, 9'h000, 2'b10);
    endtask

    task automatic test_mid_reset();
        apply(1'b1, {1'b0, 8'h01}, 2'b00);
        apply(1'b1, {1'b1, 8'h02}, 2'b00);
        apply(1'b1, {1'b0, 8'h03}, 2'b00);
        tests++; if (empty !== 2'b00) begin fails++; $display("FAIL mrst_pre: got %b want 00", empty); end
        do_reset(1'b1, {1'b1, 8'h99});
        tests++; if (empty !== 2'b11 || full !== 1'b0) begin fails++; $display("FAIL mrst_flags: got empty=%b full=%b want 11/0", empty, full); end
        tests++; if (overflow_err !== 1'b0 || dout !== 9'h000) begin fails++; $display("FAIL mrst_out: got err=%b dout=%h want 0/000", overflow_err, dout); end
        apply(1'b0, 9'h000, 2'b00);
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL mrst_nostore: got %b want 11", empty); end
    endtask

    task automatic test_back_to_back();
        logic       w;
        logic [8:0] d;
        logic [1:0] r;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 3) != 0);
            d = 9'($urandom);
            r = ($urandom_range(0, 9) == 0) ? 2'($urandom) : exp_sel_oh();
            if ($urandom_range(0, 4) == 0) r = 2'b00;
            apply(w, d, r);
            tests++;
            if (dout !== exp_dout() || empty !== exp_empty() || full !== exp_full() ||
                overflow_err !== exp_err) begin
                fails++;
                $display("FAIL b2b_%0d: got dout=%h empty=%b full=%b err=%b want %h/%b/%b/%b",
                         i, dout, empty, full, overflow_err, exp_dout(), exp_empty(),
                         exp_full(), exp_err);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        write   = 1'b0;
        din     = 9'h000;
        read    = 2'b00;
        exp_err = 1'b0;
        @(posedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_fill_wrap();
        test_same_queue();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
